scan_sel3: RTL and testbench
============================

# scan_sel3

Synchronous channel scanner that drives the enable and 3-bit select inputs of the team's 3-to-8 decoder (E, i0, i1, i2), stepping through decoder outputs y0..y7 in order. Each channel is held for a programmable dwell time. The block runs either one pass or continuously, and reports busy, wrap and done status to the controlling logic. It sits directly upstream of the decoder; its outputs connect one-to-one to the decoder's inputs.

## Interface
- DWELL_W, default 4: width of the dwell field. Each channel is held for dwell+1 cycles.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a scan; sampled only in IDLE
- stop  input  1  abort request; sampled in SCAN and IDLE
- cont  input  1  mode, latched at start: 1 = continuous scan, 0 = single pass
- dwell  input  DWELL_W  cycles-per-channel minus 1, latched at start
- E  output  1  decoder enable
- i0  output  1  select MSB (sel[2])
- i1  output  1  select middle bit (sel[1])
- i2  output  1  select LSB (sel[0]); decoder output y{sel} is active
- busy  output  1  high while in SCAN
- wrap  output  1  one-cycle pulse when sel wraps 7→0 in continuous mode
- done  output  1  one-cycle pulse after a completed single pass

## Operation
- Internal state: 3-bit sel, DWELL_W-bit dwell counter cnt, latched dwell_q and cont_q, and the FSM {IDLE, SCAN, FINISH}.
- **IDLE:** E=0, sel=0, cnt=0, busy=0.
  - start=1 and stop=0: latch dwell and cont, sel=0, cnt=0, go to SCAN.
  - start=1 and stop=1: stop wins; remain in IDLE.
- **SCAN:** E=1, busy=1, {i0,i1,i2}=sel.
  - cnt<dwell_q: cnt increments each cycle.
  - cnt==dwell_q: cnt clears and the current channel ends.
    - sel<7: sel increments.
    - sel==7 and cont_q=1: sel becomes 0 and wrap pulses.
    - sel==7 and cont_q=0: go to FINISH.
- **FINISH:** E=0, busy=0, done=1 for exactly one cycle, then go to IDLE.
- **stop in SCAN:** go to IDLE at the next edge; no done and no wrap, including when stop coincides with the final channel's expiry.
- start is ignored in SCAN and FINISH. Changes to dwell or cont during a scan have no effect until the next start.
- Arithmetic: cnt and sel are unsigned and wrap modulo 2^DWELL_W and 8 respectively. The dwell=0 case must work, giving 1 cycle per channel.

## Timing
- Reset values (first edge with rst=1): state=IDLE, E=0, i0=i1=i2=0, busy=0, wrap=0, done=0, cnt=0.
- rst overrides every other input in every state; reset mid-scan returns all outputs to their reset values at that edge.
- All outputs are registered. There is no combinational path from inputs to outputs.
- start sampled at edge n: E=1, sel=0, busy=1 from edge n onward.
- Each channel is active for exactly dwell_q+1 cycles.
- Single pass: E is high for 8·(dwell_q+1) cycles, done is high for the following cycle, and the block is back in IDLE one cycle after that. The earliest accepted restart is the cycle after done.
- Continuous mode: wrap is high in the same cycle that sel first shows 0 again. There is no gap cycle; E stays 1.
- stop sampled at edge m in SCAN: E=0 and busy=0 from edge m onward.

## Structure
- Shared package scan_pkg holds:
  - the state encoding constants (IDLE=2'd0, SCAN=2'd1, FINISH=2'd2)
  - NCH=8 and SEL_W=3, which are shared with the decoder bench
- One natural sub-module, dwell_cnt: a loadable up-counter with an expiry flag (cnt==limit), parameterised on DWELL_W. The top level instantiates it once alongside the FSM and the sel register.

## Test plan
- **Reset:** hold rst for 2 cycles with start=1 → E=0, {i0,i1,i2}=000, busy=0, done=0 throughout; no scan starts.
- **Single pass, dwell=0:** pulse start → sel steps 0..7 one cycle each, with exactly one of y0..y7 high at the decoder each cycle. done pulses in cycle 9 and busy=0 from cycle 9.
- **Continuous, dwell=2:** each sel is held 3 cycles. After 24 cycles sel=0 again with wrap=1 for one cycle and no E gap. Stop after 30 cycles → E=0 at that edge and done never asserts.
- **Stop coincident with final expiry** (cont=0, dwell=1, stop on the last cycle of sel=7) → IDLE with no done pulse.
- **Ignored inputs:** during a dwell=3 single pass, pulse start again and change dwell to 0 mid-scan → the scan continues unaffected, with 4 cycles per channel and a total E-high time of 32 cycles.
- **Reset mid-scan:** assert rst while sel=5 → next edge E=0, sel=0, busy=0, wrap=0, done=0; a later start begins at sel=0.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the channel scanner and the downstream 3-to-8 decoder bench.
package scan_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/dwell_cnt.sv
// Loadable up-counter that flags when the count reaches the programmed limit.
module dwell_cnt #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [DWELL_W-1:0] limit,
    output logic               expired
);

    logic [DWELL_W-1:0] cnt;

    assign expired = (cnt == limit);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (expired) cnt <= '0;
            else         cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/scan_sel3.sv
// Channel scanner driving the enable and select inputs of a 3-to-8 decoder,
// holding each channel for a programmable dwell, in single-pass or continuous mode.
module scan_sel3
    import scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
    output logic               E,
    output logic               i0,
    output logic               i1,
    output logic               i2,
    output logic               busy,
    output logic               wrap,
    output logic               done
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NCH - 1);

    state_t             state;
    logic [SEL_W-1:0]   sel;
    logic [DWELL_W-1:0] dwell_q;
    logic               cont_q;
    logic               expired;
    logic               cnt_en;
    logic               cnt_clr;

    // Counter runs only while scanning; a stop clears it on the same edge the FSM leaves SCAN.
    assign cnt_en  = (state == SCAN);
    assign cnt_clr = (state != SCAN) || stop;

    dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_dwell_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .limit   (dwell_q),
        .expired (expired)
    );

    assign i0 = sel[2];
    assign i1 = sel[1];
    assign i2 = sel[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            E       <= 1'b0;
            busy    <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    sel  <= '0;
                    E    <= 1'b0;
                    busy <= 1'b0;
                    if (start && !stop) begin
                        dwell_q <= dwell;
                        cont_q  <= cont;
                        state   <= SCAN;
                        E       <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                SCAN: begin
                    if (stop) begin
                        state <= IDLE;
                        sel   <= '0;
                        E     <= 1'b0;
                        busy  <= 1'b0;
                    end else if (expired) begin
                        if (sel != LAST_SEL) begin
                            sel <= sel + 1'b1;
                        end else if (cont_q) begin
                            sel  <= '0;
                            wrap <= 1'b1;
                        end else begin
                            state <= FINISH;
                            sel   <= '0;
                            E     <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    sel   <= '0;
                    E     <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    sel   <= '0;
                    E     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_sel3.sv
// Bench for scan_sel3: directed scenarios plus random traffic against a cycle-count reference model.
module tb_scan_sel3;

    localparam int DWELL_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stop;
    logic               cont;
    logic [DWELL_W-1:0] dwell;
    logic               E, i0, i1, i2, busy, wrap, done;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: position in the scan expressed as cycles elapsed since the start edge.
    bit m_active;
    bit m_done;
    int m_k;
    int m_d;
    bit m_c;

    always #5 clk = ~clk;

    scan_sel3 #(
        .DWELL_W (DWELL_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .cont  (cont),
        .dwell (dwell),
        .E     (E),
        .i0    (i0),
        .i1    (i1),
        .i2    (i2),
        .busy  (busy),
        .wrap  (wrap),
        .done  (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_k      = 0;
        end else if (m_active) begin
            if (stop) begin
                m_active = 1'b0;
            end else begin
                m_k++;
                if (!m_c && m_k == 8 * (m_d + 1)) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (start && !stop) begin
            m_active = 1'b1;
            m_k      = 0;
            m_d      = int'(dwell);
            m_c      = cont;
        end
    endtask

    task automatic compare_all();
        int   exp_sel;
        bit   exp_wrap;
        logic [7:0] y_obs;
        logic [7:0] y_exp;
        exp_sel  = m_active ? (m_k / (m_d + 1)) % 8 : 0;
        exp_wrap = m_active && m_c && m_k > 0 && (m_k % (8 * (m_d + 1))) == 0;
        y_obs    = E ? (8'd1 << {i0, i1, i2}) : 8'd0;
        y_exp    = m_active ? (8'd1 << exp_sel) : 8'd0;
        check("E",    32'(E),            32'(m_active));
        check("sel",  32'({i0, i1, i2}), 32'(exp_sel));
        check("busy", 32'(busy),         32'(m_active));
        check("wrap", 32'(wrap),         32'(exp_wrap));
        check("done", 32'(done),         32'(m_done));
        check("y",    32'(y_obs),        32'(y_exp));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int e_hi;
        m_active = 1'b0;
        m_done   = 1'b0;
        m_k      = 0;
        m_d      = 0;
        m_c      = 1'b0;
        rst   = 1'b1;
        start = 1'b1;
        stop  = 1'b0;
        cont  = 1'b0;
        dwell = '0;

        // Reset held with start asserted
        repeat (2) step();
        idle_inputs();
        step();

        // Single pass, dwell=0
        start = 1'b1; cont = 1'b0; dwell = 4'd0;
        step();
        start = 1'b0;
        repeat (12) step();

        // Continuous, dwell=2, stop after 30 cycles
        start = 1'b1; cont = 1'b1; dwell = 4'd2;
        step();
        start = 1'b0;
        repeat (29) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (4) step();

        // Stop coincident with final channel expiry
        start = 1'b1; cont = 1'b0; dwell = 4'd1;
        step();
        start = 1'b0;
        repeat (15) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (4) step();

        // Start and dwell changes ignored mid-scan
        start = 1'b1; cont = 1'b0; dwell = 4'd3;
        step();
        e_hi = int'(E);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) begin
                start = 1'b1; dwell = 4'd0; cont = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            e_hi += int'(E);
        end
        check("e_high_total", 32'(e_hi), 32'd32);

        // Reset mid-scan at sel=5, then restart
        start = 1'b1; cont = 1'b0; dwell = 4'd0;
        step();
        start = 1'b0;
        repeat (5) step();
        check("sel_before_rst", 32'({i0, i1, i2}), 32'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            cont  = 1'($urandom_range(0, 1));
            dwell = DWELL_W'($urandom_range(0, 4));
            step();
        end
        idle_inputs();
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
